// File: rtl/bmd_compl_tracker.sv
// Tracks outstanding non-posted completions for the BMD engines, emits pending/done
// pulses for turn-off control, back-pressures RX and flushes stuck work on timeout.
module bmd_compl_tracker #(
  parameter int unsigned MAX_PEND   = 4,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned TMO_CYCLES = 1024,
  parameter int unsigned TMO_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_compl_i,
  input  logic             compl_sent_i,
  input  logic             err_clr_i,
  output logic             full_o,
  output logic [CNT_W-1:0] pend_cnt_o,
  output logic             req_compl_o,
  output logic             compl_done_o,
  output logic             err_ovf_o,
  output logic             err_unf_o,
  output logic             err_tmo_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FULL, S_FLUSH} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [TMO_W-1:0] r_timer;

  logic             w_acc;
  logic             w_dec;
  logic             w_cnt_zero;
  logic             w_tmo;
  logic [CNT_W-1:0] w_next_cnt;

  // Accept/retire terms; full_o is the registered back-pressure seen by RX.
  always_comb begin
    w_cnt_zero = (r_cnt == '0);
    w_acc      = req_compl_i & ~full_o;
    w_dec      = compl_sent_i & ~w_cnt_zero;
    w_next_cnt = r_cnt + CNT_W'(w_acc) - CNT_W'(w_dec);
    w_tmo      = ((r_state == S_BUSY) || (r_state == S_FULL)) &&
                 (r_timer == TMO_W'(TMO_CYCLES - 1)) && !w_acc && !w_dec;
  end

  assign pend_cnt_o = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_timer      <= '0;
      full_o       <= 1'b0;
      req_compl_o  <= 1'b0;
      compl_done_o <= 1'b0;
      err_ovf_o    <= 1'b0;
      err_unf_o    <= 1'b0;
      err_tmo_o    <= 1'b0;
    end else begin
      // Sticky errors: a new event wins over a same-cycle clear.
      err_ovf_o <= (req_compl_i & full_o) | (err_ovf_o & ~err_clr_i);
      err_unf_o <= (compl_sent_i & w_cnt_zero) | (err_unf_o & ~err_clr_i);
      err_tmo_o <= w_tmo | (err_tmo_o & ~err_clr_i);

      if ((r_state == S_IDLE) || (r_state == S_FLUSH) || compl_sent_i || w_acc || w_tmo)
        r_timer <= '0;
      else if (!w_cnt_zero)
        r_timer <= r_timer + TMO_W'(1);

      case (r_state)
        S_FLUSH: begin
          r_state      <= S_IDLE;
          r_cnt        <= '0;
          full_o       <= 1'b0;
          req_compl_o  <= 1'b0;
          compl_done_o <= 1'b0;
        end
        default: begin
          if (w_tmo) begin
            r_state      <= S_FLUSH;
            r_cnt        <= '0;
            full_o       <= 1'b1;
            req_compl_o  <= 1'b0;
            compl_done_o <= 1'b1;
          end else begin
            r_cnt        <= w_next_cnt;
            full_o       <= (w_next_cnt == CNT_W'(MAX_PEND));
            req_compl_o  <= w_cnt_zero && (w_next_cnt != '0);
            compl_done_o <= !w_cnt_zero && (w_next_cnt == '0);
            if (w_next_cnt == '0)
              r_state <= S_IDLE;
            else if (w_next_cnt == CNT_W'(MAX_PEND))
              r_state <= S_FULL;
            else
              r_state <= S_BUSY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmd_compl_tracker.sv
// Directed, table-driven bench for bmd_compl_tracker with hand-computed expectations.
module tb_bmd_compl_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_compl_i, compl_sent_i, err_clr_i;
  logic       full_o, req_compl_o, compl_done_o;
  logic       err_ovf_o, err_unf_o, err_tmo_o;
  logic [2:0] pend_cnt_o;

  int n_chk = 0;
  int n_fail = 0;

  bmd_compl_tracker #(.MAX_PEND(4), .CNT_W(3), .TMO_CYCLES(1024), .TMO_W(10)) dut (
    .clk(clk), .rst(rst),
    .req_compl_i(req_compl_i), .compl_sent_i(compl_sent_i), .err_clr_i(err_clr_i),
    .full_o(full_o), .pend_cnt_o(pend_cnt_o),
    .req_compl_o(req_compl_o), .compl_done_o(compl_done_o),
    .err_ovf_o(err_ovf_o), .err_unf_o(err_unf_o), .err_tmo_o(err_tmo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req, sent, clr;
    logic [8:0] exp;  // {cnt[2:0], full, rq, dn, ovf, unf, tmo}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] ex(input int cnt, input bit full, input bit rq, input bit dn,
                                    input bit ovf, input bit unf, input bit tmo);
    return {3'(cnt), full, rq, dn, ovf, unf, tmo};
  endfunction

  function automatic logic [8:0] outs();
    return {pend_cnt_o, full_o, req_compl_o, compl_done_o, err_ovf_o, err_unf_o, err_tmo_o};
  endfunction

  function automatic vec_t mk(input bit req, input bit sent, input bit clr, input logic [8:0] e);
    vec_t v;
    v.req = req; v.sent = sent; v.clr = clr; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got cnt/full/rq/dn/ovf/unf/tmo=%b required=%b", name, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, land 1 time unit after it for sampling.
  task automatic cyc(input bit req, input bit sent, input bit clr);
    req_compl_i = req; compl_sent_i = sent; err_clr_i = clr;
    @(posedge clk);
    #1;
    req_compl_i = 1'b0; compl_sent_i = 1'b0; err_clr_i = 1'b0;
  endtask

  // The two pulses must never coincide.
  always @(negedge clk) begin
    if (!rst && req_compl_o && compl_done_o) begin
      n_fail++;
      $display("FAIL pulse_overlap: got rq=1 dn=1 required not both");
    end
  end

  initial begin
    // Basic request/completion, back-to-back fill, overflow, simultaneous strobes.
    vecs.push_back(mk(1, 0, 0, ex(1, 0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, 0, ex(0, 0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(1, 0, 0, ex(1, 0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk(1, 0, 0, ex(2, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(1, 0, 0, ex(3, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(1, 0, 0, ex(4, 1, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(1, 0, 0, ex(4, 1, 0, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 1, 0, ex(3, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 1, ex(3, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, 0, ex(2, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(1, 1, 0, ex(2, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, 0, ex(1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, 0, ex(0, 0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(1, 1, 0, ex(1, 0, 1, 0, 0, 1, 0)));
    vecs.push_back(mk(0, 0, 1, ex(1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, 0, ex(0, 0, 0, 1, 0, 0, 0)));

    rst = 1'b1; req_compl_i = 1'b0; compl_sent_i = 1'b0; err_clr_i = 1'b0;
    #12;
    chk("reset_state", outs(), ex(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_release", outs(), ex(0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].req, vecs[i].sent, vecs[i].clr);
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Watchdog flush at count 3, with a request arriving during the flush cycle.
    repeat (3) cyc(1, 0, 0);
    chk("tmo_fill3", outs(), ex(3, 0, 0, 0, 0, 0, 0));
    repeat (1023) cyc(0, 0, 0);
    chk("tmo_before", outs(), ex(3, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0);
    chk("tmo_flush", outs(), ex(0, 1, 0, 1, 0, 0, 1));
    cyc(1, 0, 0);
    chk("tmo_flush_req", outs(), ex(0, 0, 0, 0, 1, 0, 1));
    cyc(0, 0, 0);
    chk("tmo_after", outs(), ex(0, 0, 0, 0, 1, 0, 1));
    cyc(0, 0, 1);
    chk("tmo_clr", outs(), ex(0, 0, 0, 0, 0, 0, 0));

    // Watchdog reload by a completion at cycle 1000 of the idle wait.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("rld_fill2", outs(), ex(2, 0, 0, 0, 0, 0, 0));
    repeat (999) cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("rld_sent", outs(), ex(1, 0, 0, 0, 0, 0, 0));
    repeat (1023) cyc(0, 0, 0);
    chk("rld_no_tmo", outs(), ex(1, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0);
    chk("rld_tmo", outs(), ex(0, 1, 0, 1, 0, 0, 1));
    cyc(0, 0, 1);
    chk("rld_clr", outs(), ex(0, 0, 0, 0, 0, 0, 0));

    // Set wins over clear for the underflow flag.
    cyc(0, 1, 1);
    chk("unf_set_wins", outs(), ex(0, 0, 0, 0, 0, 1, 0));
    cyc(0, 0, 1);
    chk("unf_clr", outs(), ex(0, 0, 0, 0, 0, 0, 0));

    // Async reset in the middle of S_FULL clears outputs without a clock edge.
    repeat (4) cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("full_pre_rst", outs(), ex(4, 1, 0, 0, 1, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", outs(), ex(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 0, 0);
    chk("post_rst_req", outs(), ex(1, 0, 1, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bmd_compl_tracker.md
Name: bmd_compl_tracker

Overview:
- Counts non-posted requests accepted by the BMD RX engine that still await a completion from the TX engine.
- Collapses that count into a single pending/done pulse pair that drives the turn-off control unit's req_compl_i / compl_done_i inputs.
- Back-pressures the RX engine when the outstanding limit is reached.
- Flushes stuck completions on a watchdog timeout and flags protocol errors.

Parameters:
- MAX_PEND, 4, maximum outstanding completions (1..2^CNT_W-1).
- CNT_W, 3, width of the outstanding counter.
- TMO_CYCLES, 1024, idle cycles with work pending before timeout flush (>=2).
- TMO_W, 10, timer width; must satisfy 2^TMO_W >= TMO_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_compl_i  in  1  1-cycle strobe: RX engine accepted a request that needs a completion.
- compl_sent_i  in  1  1-cycle strobe: TX engine finished sending one completion.
- err_clr_i  in  1  clears all sticky error flags.
- full_o  out  1  high = do not issue req_compl_i.
- pend_cnt_o  out  CNT_W  current outstanding count.
- req_compl_o  out  1  1-cycle pulse on count transition 0 -> nonzero; to turn-off control req_compl_i.
- compl_done_o  out  1  1-cycle pulse on count transition nonzero -> 0, including flush; to turn-off control compl_done_i.
- err_ovf_o  out  1  sticky: req_compl_i arrived while full_o was high.
- err_unf_o  out  1  sticky: compl_sent_i arrived with count 0.
- err_tmo_o  out  1  sticky: watchdog flush occurred.

Behaviour:
- Reset (async, any time including mid-flush):
  - state=S_IDLE, count=0, timer=0.
  - full_o, req_compl_o, compl_done_o and all err_* = 0.
- All outputs are registered; each reflects the inputs sampled on the previous edge (1-cycle latency).
- Per-cycle terms:
  - acc = req_compl_i & ~full_o
  - dec = compl_sent_i & (count != 0)
  - next = count + acc - dec
  - No wrap: acc is blocked at MAX_PEND; dec is blocked at 0.
- States:
  - S_IDLE: count=0.
    - acc -> S_BUSY, or S_FULL if MAX_PEND=1; pulse req_compl_o.
  - S_BUSY: 0 < count < MAX_PEND.
    - next=0 -> S_IDLE, pulse compl_done_o.
    - next=MAX_PEND -> S_FULL.
  - S_FULL: count=MAX_PEND; full_o=1.
    - dec -> S_BUSY, or S_IDLE if MAX_PEND=1 (pulse compl_done_o).
  - S_FLUSH: one cycle. count forced 0, full_o=1, req_compl_i ignored and counted as overflow, compl_done_o pulses, err_tmo_o set. Next state S_IDLE.
- full_o = 1 in S_FULL and S_FLUSH, 0 otherwise.
- Simultaneous acc and dec: count unchanged, no pulses, timer reloads.
- compl_sent_i and req_compl_i together at count 0:
  - count becomes 1, req_compl_o pulses, err_unf_o sets.
  - The completion is not credited to the new request.
- Watchdog:
  - timer clears in S_IDLE and on any compl_sent_i or any acc.
  - Otherwise it increments each cycle while count != 0.
  - When timer == TMO_CYCLES-1 with no dec and no acc that cycle -> S_FLUSH next edge.
  - S_FLUSH is entered from S_BUSY or S_FULL.
- Sticky errors:
  - Set on their event.
  - Cleared by err_clr_i.
  - Set takes priority over clear in the same cycle.
- req_compl_o and compl_done_o never assert in the same cycle.
- A count that is nonzero at any edge is always preceded by exactly one req_compl_o pulse since the last compl_done_o.

Test Plan:
- Reset release, one req_compl_i at T0 -> req_compl_o high at T1 only, pend_cnt_o=1; compl_sent_i at T5 -> compl_done_o high at T6, pend_cnt_o=0.
- Four back-to-back req_compl_i (MAX_PEND=4) -> pend_cnt_o 1,2,3,4, full_o=1 after 4th; a 5th strobe -> count stays 4, err_ovf_o=1; one compl_sent_i -> full_o=0, count=3.
- At count=2, req_compl_i and compl_sent_i in the same cycle -> count stays 2, no pulses; at count=0 both together -> count=1, req_compl_o pulse, err_unf_o=1.
- Count=3, no completions for 1024 cycles -> S_FLUSH: compl_done_o pulse, pend_cnt_o=0, err_tmo_o=1; req_compl_i in the flush cycle -> ignored, err_ovf_o=1.
- Watchdog reload: compl_sent_i at cycle 1000 of idle wait -> no timeout until 1024 further cycles.
- err_clr_i coinciding with compl_sent_i at count 0 -> err_unf_o stays 1; err_clr_i alone next cycle -> 0; async rst asserted mid-S_FULL -> all outputs 0 immediately.
